verifier_adder_tree: RTL and testbench
======================================

// Module: verifier_adder_tree
// PURPOSE
//  Sums ngates field elements mod prime p into one canonical element v.
//  Verifier-side reduction stage: collapses per-gate partial values into one total.
//  Started by a strobe on en; reports completion with ready_pulse and a sticky ready.
// PARAMETERS
//  ngates   35   number of F_NBITS-bit summands on v_parts (>=1)
// PORTS
//  clk          in   1                  rising-edge clock, the only clock
//  rstb         in   1                  reset: asynchronous, active-low
//  en           in   1                  start; sampled at posedge, honoured only while idle
//  v_parts      in   [F_NBITS-1:0] x ngates  summands, each in [0,p)
//  ready_pulse  out  1                  high exactly one cycle when v becomes valid
//  ready        out  1                  high while idle with v holding the last valid sum
//  v            out  F_NBITS            (sum of v_parts) mod p, canonical [0,p)
// BEHAVIOUR
//  - Reset (rstb=0, async): ready=1, ready_pulse=0, v=0, all tree registers 0, state IDLE.
//  - L = $clog2(ngates) (0 when ngates=1). Total latency is L+1 posedges.
//  - IDLE: the core treats en high at posedge E0 as a start.
//    - At E0, capture all v_parts into level-0 registers.
//    - At E0, ready<=0.
//    - v_parts need only be valid at E0; the source may change them afterwards.
//  - BUSY: posedges E0+1..E0+L each reduce one tree level.
//    - Level k+1 element i = fadd(level k [2i], level k [2i+1]).
//    - An unpaired last element passes through unchanged.
//    - en is ignored while BUSY; no queueing.
//  - DONE: at posedge E0+L+1 (E0+1 if ngates=1) the core:
//    - registers v = root;
//    - sets ready_pulse=1 and ready=1;
//    - returns to IDLE.
//    - ready_pulse clears on the next posedge.
//  - Back-to-back: en high in the cycle ready_pulse is high is sampled at the next edge.
//    - That edge starts a new sum with the v_parts present then.
//    - Sampling at that edge is required; it is the normal streaming mode.
//  - v holds its value until the next DONE; it is never disturbed while BUSY.
//  - fadd(a,b): s=a+b computed in F_NBITS+1 bits; result = (s>=p) ? s-p : s.
//    - Inputs in [0,p) give a canonical output.
//    - Inputs >= p are out of contract; the result for them is undefined.
//  - Reset asserted mid-operation: abort immediately to the reset state; no ready_pulse.
//  - No X propagation: every register has a reset value.
// STRUCTURE
//  - Shared field header/package (common to the verifier) provides:
//    - `F_NBITS (field width);
//    - prime constant p (width F_NBITS);
//    - the fadd function (mirrors the simulator $f_add).
//  - Sub-module field_adder: combinational mod-p adder, ports a, b, s; instantiated per tree node.
//  - Top level contains:
//    - a generate loop over levels;
//    - a level counter (clog2(L+1) bits);
//    - a 2-state IDLE/BUSY controller;
//    - output registers.
// TESTING
//  - ngates=35, v_parts[i]=1 for all i, en pulse -> ready_pulse after 7 edges.
//    - v=35, ready=1.
//  - ngates=35, all v_parts=p-1 -> v = (35*(p-1)) mod p = p-35.
//    - Checks the wrap on every level.
//  - Streaming: set en<=ready_pulse, new random v_parts at each ready_pulse, 50 rounds.
//    - Each v equals the software fadd-fold of its own input set.
//    - Changing inputs after capture has no effect.
//  - en re-asserted while BUSY -> ignored.
//    - Exactly one ready_pulse; v equals the first capture's sum.
//  - rstb low mid-sum -> ready=1, v=0, ready_pulse=0 immediately.
//    - A fresh en then yields the correct sum.
//  - ngates=1 -> v=v_parts[0] one edge after en.
//  - ngates=2, inputs {p-1,1} -> v=0.

Source files
------------

// File: rtl/verifier_adder_tree_pkg.sv
// Field arithmetic shared by the verifier: field width, prime modulus and the mod-p adder.
// Also holds the controller state type and the tree-level sizing helper.
package verifier_adder_tree_pkg;

  localparam int F_NBITS = 32;
  localparam logic [F_NBITS-1:0] P = 32'hFFFF_FFFB;  // 2^32 - 5

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Sum of two canonical elements; inputs >= P give an undefined (but X-free) result.
  function automatic logic [F_NBITS-1:0] fadd(input logic [F_NBITS-1:0] a,
                                              input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) begin
      s = s - {1'b0, P};
    end
    return s[F_NBITS-1:0];
  endfunction

  // Element count of tree level k when level 0 holds n elements.
  function automatic int level_size(input int n, input int k);
    int m;
    m = n;
    for (int j = 0; j < k; j++) begin
      m = (m + 1) / 2;
    end
    return m;
  endfunction

endpackage

// File: rtl/verifier_adder_tree_field_adder.sv
// Combinational mod-p adder used at every internal node of the reduction tree.
module field_adder
  import verifier_adder_tree_pkg::*;
(
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] s
);

  assign s = fadd(a, b);

endmodule

// File: rtl/verifier_adder_tree.sv
// Registered binary reduction tree: sums ngates field elements mod p in $clog2(ngates)+1
// cycles after a start strobe, then presents the canonical total on v with a one-cycle pulse.
module verifier_adder_tree
  import verifier_adder_tree_pkg::*;
#(
  parameter int ngates = 35
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      en,
  input  logic [ngates*F_NBITS-1:0] v_parts,
  output logic                      ready_pulse,
  output logic                      ready,
  output logic [F_NBITS-1:0]        v
);

  localparam int L  = (ngates > 1) ? $clog2(ngates) : 0;
  localparam int CW = (L > 0) ? $clog2(L + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(L);

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     level_cnt;
  logic              start;
  logic              busy;
  logic              done;
  logic [F_NBITS-1:0] root;

  assign start = (state == IDLE) && en;
  assign busy  = (state == BUSY);
  assign done  = busy && (level_cnt == LAST);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = BUSY;
      BUSY:    if (level_cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // level_cnt counts completed reduction levels; the root is final once it reaches L.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      level_cnt <= '0;
    end else if (start) begin
      level_cnt <= '0;
    end else if (busy && !done) begin
      level_cnt <= level_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready_pulse <= 1'b0;
      ready       <= 1'b1;
      v           <= '0;
    end else begin
      ready_pulse <= done;
      if (start) begin
        ready <= 1'b0;
      end else if (done) begin
        ready <= 1'b1;
      end
      if (done) begin
        v <= root;
      end
    end
  end

  genvar gk, gi;
  generate
    for (gk = 0; gk <= L; gk++) begin : lvl
      localparam int N = level_size(ngates, gk);
      logic [F_NBITS-1:0] nodes [N];

      if (gk == 0) begin : g_capture
        always_ff @(posedge clk or negedge rstb) begin
          if (!rstb) begin
            for (int i = 0; i < N; i++) nodes[i] <= '0;
          end else if (start) begin
            for (int i = 0; i < N; i++) nodes[i] <= v_parts[i*F_NBITS +: F_NBITS];
          end
        end
      end else begin : g_reduce
        localparam int PN = level_size(ngates, gk - 1);
        logic [F_NBITS-1:0] sums [N];

        for (gi = 0; gi < N; gi++) begin : node
          if (2 * gi + 1 < PN) begin : g_pair
            field_adder u_add (
              .a (lvl[gk-1].nodes[2*gi]),
              .b (lvl[gk-1].nodes[2*gi+1]),
              .s (sums[gi])
            );
          end else begin : g_pass
            assign sums[gi] = lvl[gk-1].nodes[2*gi];
          end
        end

        always_ff @(posedge clk or negedge rstb) begin
          if (!rstb) begin
            for (int i = 0; i < N; i++) nodes[i] <= '0;
          end else if (busy) begin
            for (int i = 0; i < N; i++) nodes[i] <= sums[i];
          end
        end
      end
    end
  endgenerate

  assign root = lvl[L].nodes[0];

endmodule

// File: tb/tb_verifier_adder_tree.sv
// Directed bench for verifier_adder_tree at ngates=35, 1 and 2 with a queue of expected sums.
module tb_verifier_adder_tree;

  localparam logic [63:0] PM = 64'd4294967291;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic [2:0]        en_a = 3'b000;
  logic [2:0]        pulse_a;
  logic [2:0]        rdy_a;
  logic [31:0]       v0, v1, v2;
  logic [35*32-1:0]  parts35 = '0;
  logic [31:0]       parts1 = '0;
  logic [63:0]       parts2 = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          d;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  verifier_adder_tree #(.ngates(35)) dut35 (
    .clk(clk), .rstb(rstb), .en(en_a[0]), .v_parts(parts35),
    .ready_pulse(pulse_a[0]), .ready(rdy_a[0]), .v(v0)
  );
  verifier_adder_tree #(.ngates(1)) dut1 (
    .clk(clk), .rstb(rstb), .en(en_a[1]), .v_parts(parts1),
    .ready_pulse(pulse_a[1]), .ready(rdy_a[1]), .v(v1)
  );
  verifier_adder_tree #(.ngates(2)) dut2 (
    .clk(clk), .rstb(rstb), .en(en_a[2]), .v_parts(parts2),
    .ready_pulse(pulse_a[2]), .ready(rdy_a[2]), .v(v2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_v(input int d);
    case (d)
      0:       return v0;
      1:       return v1;
      default: return v2;
    endcase
  endfunction

  function automatic int n_of(input int d);
    case (d)
      0:       return 35;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] part(input int d, input int i);
    case (d)
      0:       return parts35[i*32 +: 32];
      1:       return parts1;
      default: return parts2[i*32 +: 32];
    endcase
  endfunction

  // Sequential fold of the current inputs, reduced with plain 64-bit modulo.
  function automatic logic [31:0] fold(input int d);
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 0; i < n_of(d); i++) acc = (acc + {32'd0, part(d, i)}) % PM;
    return acc[31:0];
  endfunction

  function automatic logic [31:0] rnd_elem();
    return $urandom % 32'hFFFF_FFFB;
  endfunction

  task automatic scramble35();
    for (int i = 0; i < 35; i++) parts35[i*32 +: 32] = rnd_elem();
  endtask

  // Called at a negedge: strobe en for one edge and record the expected sum.
  task automatic launch(input int d);
    sb.push_back('{d, fold(d)});
    en_a[d] = 1'b1;
    @(negedge clk);
    en_a[d] = 1'b0;
  endtask

  task automatic await_done(input int d, input int lat, input bit check_clear);
    int   n;
    exp_t e;
    n = 0;
    while (pulse_a[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("latency_d%0d", d), 64'(n), 64'(lat));
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{-1, 32'hDEAD_BEEF};
    check($sformatf("sb_dut_d%0d", d), 64'(d), 64'(e.d));
    check($sformatf("sum_d%0d", d), {32'd0, get_v(d)}, {32'd0, e.val});
    check($sformatf("ready_at_done_d%0d", d), {63'd0, rdy_a[d]}, 64'd1);
    $display("txn dut=%0d latency=%0d v=%0h expected=%0h", d, n, get_v(d), e.val);
    if (check_clear) begin
      @(negedge clk);
      check($sformatf("pulse_clear_d%0d", d), {63'd0, pulse_a[d]}, 64'd0);
      check($sformatf("v_hold_d%0d", d), {32'd0, get_v(d)}, {32'd0, e.val});
    end
  endtask

  initial begin
    int extra;

    // Reset state of all three instances.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready_d%0d", d), {63'd0, rdy_a[d]}, 64'd1);
      check($sformatf("rst_pulse_d%0d", d), {63'd0, pulse_a[d]}, 64'd0);
      check($sformatf("rst_v_d%0d", d), {32'd0, get_v(d)}, 64'd0);
    end
    rstb = 1'b1;
    @(negedge clk);

    // All ones: v = 35 after 7 edges.
    for (int i = 0; i < 35; i++) parts35[i*32 +: 32] = 32'd1;
    launch(0);
    check("busy_ready_low", {63'd0, rdy_a[0]}, 64'd0);
    await_done(0, 7, 1'b1);
    check("ones_v35", {32'd0, v0}, 64'd35);

    // All p-1: wraps at every level, total p-35.
    for (int i = 0; i < 35; i++) parts35[i*32 +: 32] = 32'hFFFF_FFFA;
    launch(0);
    await_done(0, 7, 1'b1);
    check("pm1_total", {32'd0, v0}, PM - 64'd35);

    // Single summand: one edge of latency.
    parts1 = rnd_elem();
    launch(1);
    await_done(1, 1, 1'b1);

    // Two summands {p-1, 1} -> 0.
    parts2 = {32'd1, 32'hFFFF_FFFA};
    launch(2);
    await_done(2, 2, 1'b1);
    check("pair_wrap_zero", {32'd0, v2}, 64'd0);

    // en re-asserted while busy with different inputs is ignored.
    scramble35();
    launch(0);
    for (int k = 0; k < 3; k++) begin
      scramble35();
      en_a[0] = 1'b1;
      @(negedge clk);
    end
    en_a[0] = 1'b0;
    await_done(0, 4, 1'b1);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (pulse_a[0] === 1'b1) extra++;
    end
    check("busy_en_single_pulse", 64'(extra), 64'd0);

    // Reset mid-sum aborts at once, then a fresh start works.
    scramble35();
    launch(0);
    repeat (2) @(negedge clk);
    rstb = 1'b0;
    #1;
    check("midrst_ready", {63'd0, rdy_a[0]}, 64'd1);
    check("midrst_v", {32'd0, v0}, 64'd0);
    check("midrst_pulse", {63'd0, pulse_a[0]}, 64'd0);
    sb.delete();
    @(negedge clk);
    rstb = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (pulse_a[0] === 1'b1) extra++;
    end
    check("midrst_no_pulse", 64'(extra), 64'd0);
    scramble35();
    launch(0);
    scramble35();
    await_done(0, 7, 1'b1);

    // Streaming: en follows ready_pulse, inputs change right after capture.
    scramble35();
    launch(0);
    scramble35();
    for (int r = 0; r < 50; r++) begin
      await_done(0, 7, 1'b0);
      if (r < 49) begin
        scramble35();
        launch(0);
        scramble35();
      end else begin
        @(negedge clk);
        check("stream_pulse_clear", {63'd0, pulse_a[0]}, 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
